// File: rtl/polybius_pkg.sv
// Shared constants and FSM state type for the Polybius encryptor/decryptor pair.
package polybius_pkg;

    localparam logic [7:0] GRID_BASE_CHAR = 8'h2A;
    localparam logic [7:0] DIGIT_BASE     = 8'h30;

    typedef enum logic {
        S_ROW = 1'b0,
        S_COL = 1'b1
    } poly_state_t;

endpackage

// File: rtl/polybius_digit_check.sv
// Combinational classifier: maps an ASCII digit to {valid, zero-based index}.
module polybius_digit_check
    import polybius_pkg::*;
#(
    parameter int GRID = 7
) (
    input  logic [7:0] in_digit,
    output logic       valid,
    output logic [7:0] index
);

    localparam logic [7:0] LOW_DIGIT  = DIGIT_BASE + 8'd1;
    localparam logic [7:0] HIGH_DIGIT = DIGIT_BASE + 8'(GRID);

    always_comb begin
        valid = (in_digit >= LOW_DIGIT) && (in_digit <= HIGH_DIGIT);
        index = in_digit - LOW_DIGIT;
    end

endmodule

// File: rtl/polybius_modified_decrypt.sv
// Polybius-square decryptor: consumes row/column ASCII digit pairs and emits one
// decoded character per pair through a single-entry ready/valid output register.
module polybius_modified_decrypt
    import polybius_pkg::*;
#(
    parameter int GRID = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_digit,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_char,
    input  logic       out_ready,
    output logic       err,
    output logic [7:0] err_count
);

    localparam logic [7:0] GRID_W = 8'(GRID);

    poly_state_t state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_char_q, out_char_d;
    logic        err_q, err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        digit_valid;
    logic [7:0]  digit_idx;
    logic        in_xfer;

    polybius_digit_check #(
        .GRID(GRID)
    ) u_digit_check (
        .in_digit(in_digit),
        .valid   (digit_valid),
        .index   (digit_idx)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        out_valid_d = out_valid_q && !out_ready;
        out_char_d  = out_char_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;

        if (in_xfer) begin
            if (!digit_valid) begin
                // A bad digit breaks the pair, so any held row is dropped.
                err_d   = 1'b1;
                state_d = S_ROW;
                row_d   = 8'h00;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end else if (state_q == S_ROW) begin
                row_d   = digit_idx;
                state_d = S_COL;
            end else begin
                out_char_d  = GRID_BASE_CHAR + row_q * GRID_W + digit_idx;
                out_valid_d = 1'b1;
                state_d     = S_ROW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ROW;
            row_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            err_q       <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule
